// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared constants and state encoding for the byte-serial add/subtract controllers.
package multibyte_add_sequencer_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/eight_bitfull_adder.sv
// Combinational 8-bit ripple-carry adder slice shared by the byte-serial sequencers.
module eight_bitfull_adder
  import multibyte_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] s_o,
  output logic              cout_o
);
  logic c;

  always_comb begin
    c   = cin_i;
    s_o = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision add/sub: one 8-bit slice per cycle, LSB first,
// carry registered between slices; result assembled by shifting in from the top.
module multibyte_add_sequencer
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [8*NBYTES-1:0]    op_a,
  input  logic [8*NBYTES-1:0]    op_b,
  output logic                   busy,
  output logic                   done,
  output logic [8*NBYTES-1:0]    result,
  output logic                   carry_out,
  output logic                   overflow
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sa_q, sa_d, sb_q, sb_d, res_q, res_d;
  logic           carry_q, carry_d, sub_q, sub_d;
  logic           cout_q, cout_d, ovf_q, ovf_d;

  logic [BYTE_W-1:0] add_b, add_s;
  logic              add_co;

  // Subtract is A + ~B + 1: the +1 enters as the initial carry loaded at accept.
  assign add_b = sb_q[BYTE_W-1:0] ^ {BYTE_W{sub_q}};

  eight_bitfull_adder u_add (
    .a_i    (sa_q[BYTE_W-1:0]),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = op_a;
          sb_d    = op_b;
          carry_d = sub;
          sub_d   = sub;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = {add_s, res_q[W-1:BYTE_W]};
        sa_d    = sa_q >> BYTE_W;
        sb_d    = sb_q >> BYTE_W;
        carry_d = add_co;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cout_d  = add_co;
          ovf_d   = (sa_q[BYTE_W-1] == add_b[BYTE_W-1]) &&
                    (add_s[BYTE_W-1] != sa_q[BYTE_W-1]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for the byte-serial add/sub sequencer (NBYTES=4 plus an NBYTES=2 instance).
module tb_multibyte_add_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [31:0] op_a, op_b, result;
  logic        busy, done, carry_out, overflow;

  logic        start2, sub2;
  logic [15:0] a2, b2, result2;
  logic        busy2, done2, co2, ov2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multibyte_add_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  multibyte_add_sequencer #(.NBYTES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .op_a(a2), .op_b(b2),
    .busy(busy2), .done(done2), .result(result2), .carry_out(co2), .overflow(ov2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Counts negedges from from_k until done is seen; at stays 0 if the bound expires.
  task automatic wait_done(input int from_k, output int at);
    at = 0;
    for (int k = from_k; k <= from_k + 20; k++) begin
      @(negedge clk);
      if (done) begin
        at = k;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] er, input logic ec, input logic ev);
    int busy_n, done_at;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_at = k;
        break;
      end
    end
    chk({tag, ".done_at"}, done_at, 5);
    chk({tag, ".busy_cycles"}, busy_n, 4);
    chk({tag, ".result"}, result, er);
    chk({tag, ".carry_out"}, carry_out, ec);
    chk({tag, ".overflow"}, overflow, ev);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int at, busy_n, done_n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    #2;
    chk("reset.outs", {busy, done, carry_out, overflow}, 4'b0000);
    chk("reset.result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("t1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("t2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("t3a", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    op_a = 32'd1; op_b = 32'd2; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3, at);
    chk("t4.done_at", at, 5);
    chk("t4.result", result, 32'h0000_0003);
    @(negedge clk);
    chk("t4.no_restart", {busy, done}, 2'b00);

    do_op("t3b", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Async reset mid-operation clears everything immediately.
    @(negedge clk);
    op_a = 32'h1111_1111; op_b = 32'h2222_2222; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5.rst_outs", {busy, done, carry_out, overflow}, 4'b0000);
    chk("t5.rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5.idle_after", {busy, done}, 2'b00);
    do_op("t5", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);

    // start held through DONE: back-to-back ops, second operands sampled in DONE.
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 op_a = 32'h0000_000F; op_b = 32'h0000_0001;
    busy_n = 0; done_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
      if (k == 5) begin
        chk("t6.first_done", {busy, done}, 2'b01);
        chk("t6.first_result", result, 32'h2345_6789);
      end
      if (k == 6) start = 1'b0;
      if (k == 10) begin
        chk("t6.second_done", {busy, done}, 2'b01);
        chk("t6.second_result", result, 32'h0000_0010);
      end
    end
    chk("t6.busy_cycles", busy_n, 8);
    chk("t6.done_pulses", done_n, 2);

    // NBYTES=2 instance.
    @(negedge clk);
    a2 = 16'hFFFF; b2 = 16'hFFFF; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done2) begin
        at = k;
        break;
      end
    end
    chk("n2.done_at", at, 3);
    chk("n2.result", result2, 16'hFFFE);
    chk("n2.flags", {co2, ov2}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
